// File: rtl/spiflash_reader.sv
// SPI mode-0 flash READ master: command + 24-bit address, then a byte stream on a valid/ready port.
// Define SPIFLASH_FAST_READ_EN to issue FAST_READ (0x0B) with an 8-clock dummy phase.
module spiflash_reader #(
  parameter int CLK_DIV     = 2,
  parameter int CS_HIGH_CYC = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [23:0] start_addr,
  input  logic        stop,
  output logic        busy,
  output logic [7:0]  dout,
  output logic        dout_valid,
  input  logic        dout_ready,
  output logic        spi_cs,
  output logic        spi_sclk,
  output logic        spi_mosi,
  input  logic        spi_miso
);
  localparam int HW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int CW = (CS_HIGH_CYC > 1) ? $clog2(CS_HIGH_CYC) : 1;
  localparam logic [HW-1:0] HC_LAST = HW'(CLK_DIV - 1);
  localparam logic [CW-1:0] CS_LAST = CW'(CS_HIGH_CYC - 1);
`ifdef SPIFLASH_FAST_READ_EN
  localparam logic [7:0] CMD = 8'h0B;
`else
  localparam logic [7:0] CMD = 8'h03;
`endif

  typedef enum logic [2:0] {
    S_IDLE, S_CMD, S_ADDR,
`ifdef SPIFLASH_FAST_READ_EN
    S_DUMMY,
`endif
    S_DATA, S_CSHIGH
  } state_e;

  state_e          state_q, state_d;
  logic [HW-1:0]   hc_q, hc_d;
  logic [2:0]      bit_q, bit_d;
  logic [4:0]      acnt_q, acnt_d;
  logic [CW-1:0]   csc_q, csc_d;
  logic [31:0]     tx_q, tx_d;
  logic [6:0]      rx_q, rx_d;
  logic [7:0]      dout_q, dout_d;
  logic            dv_q, dv_d, sclk_q, sclk_d, cs_q, cs_d, mosi_q, mosi_d, busy_q, busy_d;

  always_comb begin
    state_d = state_q;  hc_d   = hc_q;   bit_d  = bit_q;   acnt_d = acnt_q;
    csc_d   = csc_q;    tx_d   = tx_q;   rx_d   = rx_q;    dout_d = dout_q;
    dv_d    = dv_q & ~dout_ready;
    sclk_d  = sclk_q;   cs_d   = cs_q;   mosi_d = mosi_q;  busy_d = busy_q;
    case (state_q)
      S_IDLE: if (start) begin
        state_d = S_CMD;  cs_d = 1'b0;  busy_d = 1'b1;  sclk_d = 1'b0;
        hc_d = '0;  bit_d = '0;  acnt_d = '0;
        mosi_d = CMD[7];
        tx_d = {CMD[6:0], start_addr, 1'b0};
      end
      S_CSHIGH: begin
        if (csc_q == CS_LAST) begin
          state_d = S_IDLE;
          busy_d  = 1'b0;
        end else begin
          csc_d = csc_q + 1'b1;
        end
      end
      default: begin
        if (hc_q != HC_LAST) begin
          hc_d = hc_q + 1'b1;
        end else if (!sclk_q) begin
          // The 8th rise of a data byte waits, count frozen, until dout can take the byte.
          if (!(state_q == S_DATA && bit_q == 3'd7 && dv_q && !dout_ready)) begin
            sclk_d = 1'b1;
            hc_d   = '0;
            if (state_q == S_DATA) begin
              rx_d = {rx_q[5:0], spi_miso};
              if (bit_q == 3'd7) begin
                dout_d = {rx_q, spi_miso};
                dv_d   = 1'b1;
              end
            end
          end
        end else begin
          sclk_d = 1'b0;
          hc_d   = '0;
          bit_d  = bit_q + 1'b1;
          mosi_d = tx_q[31];
          tx_d   = {tx_q[30:0], 1'b0};
          case (state_q)
            S_CMD:  if (bit_q == 3'd7) state_d = S_ADDR;
            S_ADDR: begin
              acnt_d = acnt_q + 5'd1;
              if (acnt_q == 5'd23) begin
                acnt_d = '0;
                bit_d  = '0;
`ifdef SPIFLASH_FAST_READ_EN
                state_d = S_DUMMY;
`else
                state_d = S_DATA;
`endif
              end
            end
`ifdef SPIFLASH_FAST_READ_EN
            S_DUMMY: if (bit_q == 3'd7) state_d = S_DATA;
`endif
            default: ;
          endcase
        end
      end
    endcase
    // Stop abandons any partial byte but leaves a byte already in dout untouched.
    if (stop && state_q != S_IDLE && state_q != S_CSHIGH) begin
      state_d = S_CSHIGH;  cs_d = 1'b1;  sclk_d = 1'b0;  mosi_d = 1'b0;
      csc_d   = '0;
      dout_d  = dout_q;
      dv_d    = dv_q & ~dout_ready;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;  hc_q <= '0;  bit_q <= '0;  acnt_q <= '0;  csc_q <= '0;
      tx_q    <= '0;      rx_q <= '0;  dout_q <= '0; dv_q   <= 1'b0;
      sclk_q  <= 1'b0;    cs_q <= 1'b1; mosi_q <= 1'b0; busy_q <= 1'b0;
    end else begin
      state_q <= state_d; hc_q <= hc_d; bit_q <= bit_d; acnt_q <= acnt_d; csc_q <= csc_d;
      tx_q    <= tx_d;    rx_q <= rx_d; dout_q <= dout_d; dv_q <= dv_d;
      sclk_q  <= sclk_d;  cs_q <= cs_d; mosi_q <= mosi_d; busy_q <= busy_d;
    end
  end

  assign busy       = busy_q;
  assign dout       = dout_q;
  assign dout_valid = dv_q;
  assign spi_cs     = cs_q;
  assign spi_sclk   = sclk_q;
  assign spi_mosi   = mosi_q;
endmodule

// File: tb/tb_spiflash_reader.sv
// Bench for spiflash_reader: flash behavioural model on the SPI pins plus an address-based byte scoreboard.
// Honours SPIFLASH_FAST_READ_EN to expect the FAST_READ command and dummy phase.
module tb_spiflash_reader;
  localparam int CLK_DIV     = 2;
  localparam int CS_HIGH_CYC = 4;
`ifdef SPIFLASH_FAST_READ_EN
  localparam int          DUM   = 8;
  localparam logic [7:0]  CMD   = 8'h0B;
  localparam int          FIRST = 191;
`else
  localparam int          DUM   = 0;
  localparam logic [7:0]  CMD   = 8'h03;
  localparam int          FIRST = 159;
`endif

  logic        clk = 1'b0, reset = 1'b1, start = 1'b0, stop = 1'b0, dout_ready = 1'b0;
  logic [23:0] start_addr = '0;
  logic        spi_miso = 1'b0;
  logic        busy, dout_valid, spi_cs, spi_sclk, spi_mosi;
  logic [7:0]  dout;

  always #5 clk = ~clk;

  spiflash_reader #(.CLK_DIV(CLK_DIV), .CS_HIGH_CYC(CS_HIGH_CYC)) dut (
    .clk(clk), .reset(reset), .start(start), .start_addr(start_addr), .stop(stop),
    .busy(busy), .dout(dout), .dout_valid(dout_valid), .dout_ready(dout_ready),
    .spi_cs(spi_cs), .spi_sclk(spi_sclk), .spi_mosi(spi_mosi), .spi_miso(spi_miso)
  );

  function automatic logic [7:0] mem_byte(input logic [23:0] a);
    case (a)
      24'h000100: return 8'hF3;
      24'h000101: return 8'hAF;
      24'h000102: return 8'h11;
      24'h000103: return 8'hFF;
      default:    return a[7:0] ^ 8'h5A;
    endcase
  endfunction

  // Flash model: shifts in 32 header bits on SCLK rises, presents data MSB-first on SCLK falls.
  int          fl_bits = 0;
  logic [31:0] fl_in   = '0;
  logic        fl_prev = 1'b0;
  always @(spi_sclk or spi_cs) begin
    int idx;
    logic [7:0] b;
    if (spi_cs) begin
      fl_bits  = 0;
      spi_miso = 1'b0;
    end else if (spi_sclk && !fl_prev) begin
      if (fl_bits < 32) fl_in = {fl_in[30:0], spi_mosi};
      fl_bits++;
    end else if (!spi_sclk && fl_prev && fl_bits >= 32 + DUM) begin
      idx = fl_bits - 32 - DUM;
      b = mem_byte(fl_in[23:0] + 24'(idx / 8));
      spi_miso = b[7 - (idx % 8)];
    end
    fl_prev = spi_sclk;
  end

  int          total = 0, bad = 0, tcnt = 0, sb_idx = 0;
  logic [23:0] sb_addr = '0;
  logic        pv = 1'b0, pmosi = 1'b0, vld_seen = 1'b0;
  logic [7:0]  pd = '0;
  logic [7:0]  rcv[$];

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, got, exp, tcnt);
    end
  endtask

  // One clock: sample at the falling edge, account for last edge's handshake, check outputs.
  task automatic tick();
    @(negedge clk);
    tcnt++;
    if (pv && dout_ready) begin
      rcv.push_back(pd);
      sb_idx++;
    end
    if (start) sb_idx = 0;
    if (dout_valid) begin
      vld_seen = 1'b1;
      chk("dout_sb", 32'(dout), 32'(mem_byte(sb_addr + 24'(sb_idx))));
    end
    chk("cs_sclk", 32'(spi_cs & spi_sclk), 0);
    chk("mosi_hold", 32'((spi_mosi !== pmosi) & spi_sclk), 0);
    if (pv && !dout_ready && !reset) chk("dout_hold", 32'({dout_valid, dout}), 32'({1'b1, pd}));
    pv = dout_valid;  pd = dout;  pmosi = spi_mosi;
  endtask

  task automatic go(input logic [23:0] a, output int st);
    rcv.delete();
    sb_addr = a;  start_addr = a;  start = 1'b1;  st = tcnt;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_valid(input string nm, input int lim);
    int n = 0;
    while (!dout_valid && n < lim) begin tick(); n++; end
    if (!dout_valid) chk(nm, 32'(dout_valid), 1);
  endtask

  task automatic wait_rcv(input string nm, input int k, input int lim);
    int n = 0;
    while (rcv.size() < k && n < lim) begin tick(); n++; end
    if (rcv.size() < k) chk(nm, 32'(rcv.size()), 32'(k));
  endtask

  task automatic end_burst();
    int n = 0;
    stop = 1'b1;  tick();  stop = 1'b0;
    while (busy && n < 50) begin tick(); n++; end
    if (busy) chk("idle_timeout", 32'(busy), 0);
  endtask

  task automatic chk_bytes(input string nm);
    logic [7:0] want [4] = '{8'hF3, 8'hAF, 8'h11, 8'hFF};
    for (int i = 0; i < 4; i++)
      chk(nm, (i < rcv.size()) ? 32'(rcv[i]) : 32'hDEAD, 32'(want[i]));
  endtask

  initial begin
    int st, t1, n;
    repeat (3) tick();
    chk("rst_cs", 32'(spi_cs), 1);
    chk("rst_sclk", 32'(spi_sclk), 0);
    chk("rst_mosi", 32'(spi_mosi), 0);
    chk("rst_dout", 32'(dout), 0);
    chk("rst_valid", 32'(dout_valid), 0);
    chk("rst_busy", 32'(busy), 0);
    reset = 1'b0;
    tick();

    // Free-running read at 0x100
    dout_ready = 1'b1;
    go(24'h000100, st);
    chk("c1_cs", 32'(spi_cs), 0);
    chk("c1_busy", 32'(busy), 1);
    wait_valid("t1_first_timeout", 400);
    chk("t1_latency", 32'(tcnt - st), 32'(FIRST));
    chk("t1_header", fl_in, {CMD, 24'h000100});
    t1 = tcnt;
    n = 0;
    while (dout_valid && n < 10) begin tick(); n++; end
    wait_valid("t1_second_timeout", 100);
    chk("t1_byte_gap", 32'(tcnt - t1), 32'(16 * CLK_DIV));
    wait_rcv("t1_rcv_timeout", 4, 200);
    chk_bytes("t1_bytes");
    end_burst();

    // Backpressure: hold the first byte for 100 cycles
    dout_ready = 1'b0;
    go(24'h000100, st);
    wait_valid("t2_first_timeout", 400);
    repeat (100) tick();
    chk("t2_dout", 32'(dout), 32'h00F3);
    chk("t2_valid", 32'(dout_valid), 1);
    chk("t2_sclk_low", 32'(spi_sclk), 0);
    chk("t2_rises", 32'(fl_bits), 32'(47 + DUM));
    dout_ready = 1'b1;
    wait_rcv("t2_rcv_timeout", 4, 300);
    chk_bytes("t2_bytes");
    end_burst();

    // Stop in the middle of the address phase
    dout_ready = 1'b1;
    go(24'h000100, st);
    vld_seen = 1'b0;
    n = 0;
    while (fl_bits < 18 && n < 200) begin tick(); n++; end
    if (fl_bits < 18) chk("t3_addr_timeout", 32'(fl_bits), 18);
    stop = 1'b1;  tick();  stop = 1'b0;
    chk("t3_cs", 32'(spi_cs), 1);
    chk("t3_sclk", 32'(spi_sclk), 0);
    n = 0;
    while (busy && n < 20) begin n++; tick(); end
    chk("t3_busy_len", 32'(n), 32'(CS_HIGH_CYC));
    chk("t3_no_valid", 32'(vld_seen), 0);

    // Stop with a byte pending in dout
    dout_ready = 1'b0;
    go(24'h000100, st);
    wait_valid("t4_first_timeout", 400);
    repeat (10) tick();
    stop = 1'b1;  tick();  stop = 1'b0;
    repeat (20) tick();
    chk("t4_busy", 32'(busy), 0);
    chk("t4_valid", 32'(dout_valid), 1);
    chk("t4_dout", 32'(dout), 32'h00F3);
    dout_ready = 1'b1;  tick();  dout_ready = 1'b0;
    chk("t4_cleared", 32'(dout_valid), 0);
    chk("t4_rcv_n", 32'(rcv.size()), 1);
    vld_seen = 1'b0;
    repeat (50) tick();
    chk("t4_no_more", 32'(vld_seen), 0);

    // Reset during DATA, then restart at address 0
    dout_ready = 1'b1;
    go(24'h000100, st);
    wait_rcv("t5_rcv_timeout", 2, 400);
    reset = 1'b1;  tick();  reset = 1'b0;
    chk("t5_cs", 32'(spi_cs), 1);
    chk("t5_sclk", 32'(spi_sclk), 0);
    chk("t5_mosi", 32'(spi_mosi), 0);
    chk("t5_dout", 32'(dout), 0);
    chk("t5_valid", 32'(dout_valid), 0);
    chk("t5_busy", 32'(busy), 0);
    go(24'h000000, st);
    wait_valid("t5_first_timeout", 400);
    chk("t5_mem0", 32'(dout), 32'h005A);
    chk("t5_header", fl_in, {CMD, 24'h000000});
    end_burst();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/spiflash_reader.md
# spiflash_reader

Synthesizable SPI mode-0 flash read master. It issues a READ (0x03) command with a 24-bit address, then streams data bytes to the fabric through a valid/ready byte port, holding SCLK low whenever the consumer stalls. It sits between the ROM/loader logic and the board's SPI flash pins. In simulation it is the initiator that drives the team's flash behavioural model.

## Interface
- `CLK_DIV`, default 2: SCLK half-period in `clk` cycles; must be ≥1.
- `CS_HIGH_CYC`, default 4: minimum CS-deselect time in `clk` cycles after a burst; must be ≥1.

Ports:
- `clk`  in  1  system clock; the only clock.
- `reset`  in  1  synchronous, active-high reset.
- `start`  in  1  one-cycle burst request; sampled only in IDLE.
- `start_addr`  in  24  flash byte address, captured with `start`.
- `stop`  in  1  ends the burst; honoured in any non-IDLE state.
- `busy`  out  1  high from the cycle after `start` is accepted until CS_HIGH completes.
- `dout`  out  8  received byte.
- `dout_valid`  out  1  `dout` holds an unconsumed byte.
- `dout_ready`  in  1  consumer accepts `dout` when high together with `dout_valid`.
- `spi_cs`  out  1  flash chip select, active low.
- `spi_sclk`  out  1  SPI clock; idles low.
- `spi_mosi`  out  1  command and address bits, MSB first.
- `spi_miso`  in  1  data from the flash.

## Operation
- States: IDLE, CMD (8 bits), ADDR (24 bits), DUMMY (8 bits, macro only), DATA, CSHIGH.
- IDLE + `start`: capture the address, drive `spi_cs`=0, enter CMD.
- CMD → ADDR → (DUMMY) → DATA. Each transition occurs after the last falling edge of the phase.
- Bit timing, mode 0:
  - SCLK low for `CLK_DIV` cycles, then high for `CLK_DIV` cycles.
  - `spi_mosi` changes only while SCLK is low; it is driven on the first low cycle of each bit.
  - `spi_miso` is sampled in the `clk` cycle in which SCLK rises.
- DATA phase:
  - Shift 8 bits MSB first into a shift register.
  - The 8th rising edge of a byte is issued only if the output register is free, i.e. `dout_valid`=0, or `dout_valid`&`dout_ready` in that cycle.
  - Otherwise SCLK stays low, and the count of the low phase is frozen.
  - On the 8th rising edge, the byte loads into `dout` and `dout_valid` becomes 1 in the same cycle.
- Consume: `dout_valid`&`dout_ready` clears `dout_valid` next cycle, unless a new byte loads in that same cycle, in which case `dout_valid` stays 1.
- DATA continues indefinitely. Address wrap-around is handled by the flash, not tracked here.
- `stop` (any non-IDLE state):
  - Next cycle: SCLK=0, `spi_cs`=1, enter CSHIGH.
  - Any partially shifted byte is discarded.
  - A byte already in `dout` stays valid until it is consumed.
- CSHIGH: hold `spi_cs`=1 for `CS_HIGH_CYC` cycles, then go to IDLE. `busy` falls on entry to IDLE.
- `start` in a non-IDLE state is ignored.
- `stop` and `start` in the same IDLE cycle: `start` wins. `stop` is ignored in IDLE.

## Timing
- Reset values: `spi_cs`=1, `spi_sclk`=0, `spi_mosi`=0, `dout`=0x00, `dout_valid`=0, `busy`=0; state IDLE.
- Reset mid-burst produces these values in the next cycle. The flash sees CS rise with SCLK low.
- `start` at cycle 0 → `spi_cs`=0 and `busy`=1 at cycle 1; first SCLK rise at cycle 1+`CLK_DIV`.
- One bit = 2·`CLK_DIV` cycles.
- First `dout_valid` (no stall, READ): 40 bits after CS falls, i.e. at cycle 1 + 78·`CLK_DIV` + `CLK_DIV` = 1 + 79·`CLK_DIV`.
- Sustained throughput with `dout_ready`=1: one byte per 16·`CLK_DIV` cycles.
- Counters: bit counter 0–7, address phase 0–23, half-period counter sized for `CLK_DIV`, CS counter sized for `CS_HIGH_CYC`. No other arithmetic.

## Configuration
- `SPIFLASH_FAST_READ_EN` defined:
  - Command is 0x0B.
  - A DUMMY phase of 8 clocks follows ADDR, with MOSI=0 and MISO ignored.
  - First `dout_valid` is delayed by 16·`CLK_DIV` cycles.
- Not defined:
  - Command is 0x03 with no DUMMY state.
  - The DUMMY logic is compiled out.

## Test plan
- Macro undefined, `CLK_DIV`=2, `start_addr`=0x000100, flash bytes at 0x100..0x103 = 0xF3,0xAF,0x11,0xFF, `dout_ready`=1 → MOSI bits 0x03,0x00,0x01,0x00; `dout` sequence F3,AF,11,FF; first valid at cycle 159.
- Backpressure: `dout_ready`=0 for 100 cycles after the first byte → SCLK holds low before the 8th rise of byte 2; `dout`=0xF3 stable; no byte lost after release.
- `stop` mid-address (bit 10) → next cycle CS=1, SCLK=0; `busy` high exactly `CS_HIGH_CYC` more cycles; `dout_valid` never rises.
- `stop` with one byte pending in `dout` → byte retained until `dout_ready`; no further bytes.
- `reset` during DATA → next cycle all outputs at reset values. A new `start` at 0x000000 returns memory[0] first.
- Macro defined → MOSI command 0x0B, 8 dummy clocks, first valid delayed by 32 cycles versus the undefined build.
